// File: rtl/ps2_frame_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ps2_frame_ctrl_pkg
// Shared definitions for the PS/2 receive sequencer:
//   - frame_state_t : frame FSM state encoding
//   - frame_fsm_t   : the complete FSM register (state + data-bit counter),
//                     kept as one struct so the whole FSM is observable as a
//                     single signal
//   - PS2_EXT/BRK   : scancode prefix bytes for extended keys and releases
//   - odd_parity_ok : checks a data byte against its received parity bit
// ----------------------------------------------------------------------------
package ps2_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    typedef struct packed {
        frame_state_t state;
        logic [2:0]   bitcnt;
    } frame_fsm_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // PS/2 uses odd parity: the 8 data bits plus the parity bit must contain
    // an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic p);
        return (^data) ^ p;
    endfunction

endpackage

// File: rtl/ps2_prefix_tracker.sv
// ----------------------------------------------------------------------------
// ps2_prefix_tracker
// Turns a stream of good PS/2 bytes into key events. E0 and F0 bytes only set
// the pending extended / break flags; any other byte produces a one-cycle
// event carrying the byte and the flags, after which the flags clear.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   byte_vld   1-cycle strobe: byte_in is a correctly framed byte
//   byte_in    received byte
//   flag_clr   drop any pending prefix (framing error or timeout)
//   code_en    1-cycle event strobe (registered)
//   code       scancode of the last event (held between events)
//   ext, brk   prefix flags of the last event (held between events)
// ----------------------------------------------------------------------------
module ps2_prefix_tracker
    import ps2_frame_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_vld,
    input  logic [7:0] byte_in,
    input  logic       flag_clr,
    output logic       code_en,
    output logic [7:0] code,
    output logic       ext,
    output logic       brk
);

    logic ext_pend;
    logic brk_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            code_en  <= 1'b0;
            code     <= 8'h00;
            ext      <= 1'b0;
            brk      <= 1'b0;
        end else begin
            code_en <= 1'b0;
            if (flag_clr) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (byte_vld) begin
                if (byte_in == PS2_EXT) begin
                    ext_pend <= 1'b1;
                end else if (byte_in == PS2_BRK) begin
                    // ext_pend is left alone so E0 F0 xx reports both flags
                    brk_pend <= 1'b1;
                end else begin
                    code_en  <= 1'b1;
                    code     <= byte_in;
                    ext      <= ext_pend;
                    brk      <= brk_pend;
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_frame_ctrl.sv
// ----------------------------------------------------------------------------
// ps2_frame_ctrl
// PS/2 receive sequencer. Frames 11-bit packets (start, 8 data LSB first,
// odd parity, stop) on the synchronised falling-edge strobe, checks framing,
// and forwards good bytes to the prefix tracker which emits key events.
// A watchdog returns the frame FSM to IDLE when a frame stalls.
// Ports:
//   clk        system clock
//   i_aclr     asynchronous reset, active-high
//   i_edge_en  1-cycle strobe per PS/2 clock falling edge
//   i_dat      PS/2 data, only looked at while i_edge_en=1
//   o_code_en  1-cycle strobe, o_code/o_ext/o_brk valid
//   o_code     scancode (prefixes stripped), held between strobes
//   o_ext      event was preceded by E0
//   o_brk      event was preceded by F0 (key release)
//   o_err_en   1-cycle strobe on start/parity/stop error or timeout
//   o_busy     frame FSM is inside a frame
// Handshake: strobes only, no back-pressure. o_code_en and o_err_en are
// registered and rise the cycle after the i_edge_en that completed (or the
// cycle that timed out) the frame; they are mutually exclusive.
// ----------------------------------------------------------------------------
module ps2_frame_ctrl
    import ps2_frame_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 5000,
    parameter int TMR_W       = 13
) (
    input  logic       clk,
    input  logic       i_aclr,
    input  logic       i_edge_en,
    input  logic       i_dat,
    output logic       o_code_en,
    output logic [7:0] o_code,
    output logic       o_ext,
    output logic       o_brk,
    output logic       o_err_en,
    output logic       o_busy
);

    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);

    // FSM register: state and data-bit counter, visible as one signal
    frame_fsm_t       fsm_q, fsm_d;
    logic [7:0]       sr_q, sr_d;
    logic             par_q, par_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             err_q, err_d;
    logic             good_stb;
    logic             timeout;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge i_aclr) begin
        if (i_aclr) begin
            fsm_q   <= '{state: ST_IDLE, bitcnt: 3'd0};
            sr_q    <= 8'h00;
            par_q   <= 1'b0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            sr_q    <= sr_d;
            par_q   <= par_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    // ---------------- next state / outputs ----------------
    always_comb begin
        fsm_d    = fsm_q;
        sr_d     = sr_q;
        par_d    = par_q;
        err_d    = 1'b0;
        good_stb = 1'b0;
        // An edge arriving in the last timer cycle keeps the frame alive.
        timeout  = (fsm_q.state != ST_IDLE) && !i_edge_en && (timer_q == TMO_LAST);

        if (i_edge_en) begin
            case (fsm_q.state)
                ST_IDLE: begin
                    // a high level here is line noise or idle, not an error
                    if (!i_dat) begin
                        fsm_d.state  = ST_DATA;
                        fsm_d.bitcnt = 3'd0;
                    end
                end
                ST_DATA: begin
                    sr_d         = {i_dat, sr_q[7:1]};
                    fsm_d.bitcnt = fsm_q.bitcnt + 3'd1;
                    if (fsm_q.bitcnt == 3'd7) begin
                        fsm_d.state = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d       = i_dat;
                    fsm_d.state = ST_STOP;
                end
                ST_STOP: begin
                    fsm_d.state = ST_IDLE;
                    if (i_dat && odd_parity_ok(sr_q, par_q)) begin
                        good_stb = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: fsm_d.state = ST_IDLE;
            endcase
        end else if (timeout) begin
            fsm_d.state = ST_IDLE;
            err_d       = 1'b1;
        end

        // watchdog: measures the gap since the last edge while in a frame
        if (i_edge_en || (fsm_q.state == ST_IDLE)) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    // sr_q still holds the completed byte during STOP
    ps2_prefix_tracker u_prefix (
        .clk      (clk),
        .rst      (i_aclr),
        .byte_vld (good_stb),
        .byte_in  (sr_q),
        .flag_clr (err_d),
        .code_en  (o_code_en),
        .code     (o_code),
        .ext      (o_ext),
        .brk      (o_brk)
    );

    assign o_err_en = err_q;
    assign o_busy   = (fsm_q.state != ST_IDLE);

endmodule

// File: tb/tb_ps2_frame_ctrl.sv
module tb_ps2_frame_ctrl;

    localparam int TMO = 5000;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       i_aclr;
    logic       i_edge_en;
    logic       i_dat;
    logic       o_code_en;
    logic [7:0] o_code;
    logic       o_ext;
    logic       o_brk;
    logic       o_err_en;
    logic       o_busy;

    always #5 clk = ~clk;

    ps2_frame_ctrl #(.TIMEOUT_CYC(TMO), .TMR_W(13)) dut (
        .clk       (clk),
        .i_aclr    (i_aclr),
        .i_edge_en (i_edge_en),
        .i_dat     (i_dat),
        .o_code_en (o_code_en),
        .o_code    (o_code),
        .o_ext     (o_ext),
        .o_brk     (o_brk),
        .o_err_en  (o_err_en),
        .o_busy    (o_busy)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    logic [9:0] exp_q[$];   // {ext, brk, code}
    logic [9:0] obs_q[$];
    int         exp_err = 0;
    int         obs_err = 0;
    bit         m_ext   = 1'b0;
    bit         m_brk   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // monitor: records every event and error strobe
    always @(negedge clk) begin
        if (o_code_en === 1'b1) obs_q.push_back({o_ext, o_brk, o_code});
        if (o_err_en === 1'b1) obs_err++;
        if (o_code_en === 1'b1 || o_err_en === 1'b1) begin
            checks++;
            assert (!(o_code_en === 1'b1 && o_err_en === 1'b1)) else begin
                failures++;
                $error("FAIL strobe_exclusive observed=%b%b expected=not both", o_code_en, o_err_en);
            end
        end
    end

    // reference model: what a complete 11-bit frame means for the key stream
    task automatic model_frame(input logic [7:0] b, input bit good);
        if (!good) begin
            exp_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            exp_q.push_back({m_ext, m_brk, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_timeout();
        exp_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic check_events(input string tag);
        while (exp_q.size() > 0) begin
            chk({tag, "_evt_present"}, 32'(obs_q.size() > 0), 32'd1);
            if (obs_q.size() > 0) chk({tag, "_evt"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
            else void'(exp_q.pop_front());
        end
        chk({tag, "_no_extra_evt"}, 32'(obs_q.size()), 32'd0);
        chk({tag, "_err_cnt"}, 32'(obs_err), 32'(exp_err));
        obs_q.delete();
    endtask

    // ---------------- drivers ----------------
    // Caller is positioned just after a rising edge; returns just after the
    // rising edge that sampled the bit.
    task automatic send_bit(input logic b);
        i_dat     = b;
        i_edge_en = 1'b1;
        @(posedge clk); #1;
        i_edge_en = 1'b0;
        i_dat     = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic p;
        p = ~(^b) ^ bad_par;
        return {~bad_stop, p, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] fr, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            send_bit(fr[i]);
            if (i < last) begin
                int g;
                g = $urandom_range(0, 4);
                repeat (g) begin @(posedge clk); #1; end
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        send_bits(frame_of(b, bad_par, bad_stop), 0, 10);
        model_frame(b, !bad_par && !bad_stop);
    endtask

    task automatic settle();
        repeat (3) begin @(posedge clk); #1; end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [10:0] fr;
        i_aclr    = 1'b1;
        i_edge_en = 1'b0;
        i_dat     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_code_en", 32'(o_code_en), 32'd0);
        chk("rst_code", 32'(o_code), 32'd0);
        chk("rst_err_en", 32'(o_err_en), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        i_aclr = 1'b0;
        settle();

        // idle-level edges outside a frame are ignored
        send_bit(1'b1);
        send_bit(1'b1);
        chk("idle_high_busy", 32'(o_busy), 32'd0);
        settle();
        check_events("idle_high");

        // 1: plain make code, latency one cycle after the stop edge
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("t1_code_en", 32'(o_code_en), 32'd1);
        chk("t1_code", 32'(o_code), 32'h1C);
        chk("t1_flags", 32'({o_ext, o_brk}), 32'd0);
        @(posedge clk); #1;
        chk("t1_pulse_width", 32'(o_code_en), 32'd0);
        chk("t1_code_held", 32'(o_code), 32'h1C);
        settle();
        check_events("t1");

        // 2: break
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        settle();
        check_events("t2");

        // 3: extended break, then plain repeat
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        settle();
        check_events("t3");

        // 4: parity error drops pending E0
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b0);
        chk("t4_err_en", 32'(o_err_en), 32'd1);
        chk("t4_no_code_en", 32'(o_code_en), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b0);
        settle();
        check_events("t4");

        // stop-bit error
        send_frame(8'h33, 1'b0, 1'b1);
        settle();
        check_events("stop_err");

        // 5: stall after start + 4 data bits
        fr = frame_of(8'h29, 1'b0, 1'b0);
        send_bits(fr, 0, 4);
        repeat (TMO - 1) @(posedge clk);
        #1;
        chk("t5_busy_before_tmo", 32'(o_busy), 32'd1);
        chk("t5_no_err_before_tmo", 32'(o_err_en), 32'd0);
        @(posedge clk); #1;
        chk("t5_err_at_tmo", 32'(o_err_en), 32'd1);
        chk("t5_idle_at_tmo", 32'(o_busy), 32'd0);
        model_timeout();
        send_frame(8'h29, 1'b0, 1'b0);
        settle();
        check_events("t5");

        // edge in the last timer cycle keeps the frame alive
        send_frame(8'hE0, 1'b0, 1'b0);
        fr = frame_of(8'h4B, 1'b0, 1'b0);
        send_bits(fr, 0, 3);
        repeat (TMO - 1) begin @(posedge clk); #1; end
        send_bits(fr, 4, 10);
        model_frame(8'h4B, 1'b1);
        settle();
        check_events("edge_wins");

        // 6: asynchronous reset mid-frame with E0 pending
        send_frame(8'hE0, 1'b0, 1'b0);
        settle();
        send_bits(frame_of(8'h66, 1'b0, 1'b0), 0, 5);
        i_aclr = 1'b1;
        #1;
        chk("t6_code_rst", 32'(o_code), 32'd0);
        chk("t6_flags_rst", 32'({o_ext, o_brk}), 32'd0);
        chk("t6_busy_rst", 32'(o_busy), 32'd0);
        m_ext = 1'b0;
        m_brk = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        i_aclr = 1'b0;
        settle();
        send_frame(8'h5A, 1'b0, 1'b0);
        settle();
        check_events("t6");

        // random traffic: prefixes, E1, arbitrary codes, occasional bad frames
        for (int n = 0; n < 40; n++) begin
            int          r;
            logic [7:0]  b;
            r = $urandom_range(0, 9);
            if (r < 2)       b = 8'hE0;
            else if (r < 4)  b = 8'hF0;
            else if (r == 4) b = 8'hE1;
            else             b = 8'($urandom_range(0, 255));
            send_frame(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0));
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            settle();
            check_events("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
